// File: rtl/cpb_pkg.sv
// rtl/cpb_pkg.sv - shared CPB state codes, phase indices and scheduler state encoding
package cpb_pkg;

  localparam int FSM_BITS = 5;
  localparam int N_PHASES = 7;

  // State codes of the CPB sequencing FSM
  typedef enum logic [FSM_BITS-1:0] {
    ST_IDLE       = 5'd0,
    ST_FIRST_LOAD = 5'd1,
    ST_CPB_0      = 5'd2,
    ST_CPB_1      = 5'd3,
    ST_CPB_2      = 5'd4,
    ST_CPB_LOADNW = 5'd5,
    ST_CPB_3      = 5'd6,
    ST_CPB_4      = 5'd7
  } cpb_state_e;

  // Phase index = state code - 1; also the bit position in flag_end
  typedef enum logic [2:0] {
    PH_FIRST_LOAD = 3'd0,
    PH_CPB_0      = 3'd1,
    PH_CPB_1      = 3'd2,
    PH_CPB_2      = 3'd3,
    PH_LOADNEW    = 3'd4,
    PH_CPB_3      = 3'd5,
    PH_CPB_4      = 3'd6
  } phase_idx_e;

  // Scheduler tracking state
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } sched_state_e;

  function automatic logic is_load_phase(input logic [2:0] idx);
    return (idx == 3'(PH_FIRST_LOAD)) || (idx == 3'(PH_LOADNEW));
  endfunction

endpackage

// File: rtl/cpb_phase_counter.sv
// rtl/cpb_phase_counter.sv - phase cycle counter with latched length and terminal compare
module cpb_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_len,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term_next
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  // Clear, load (count restarts at 1, zero length treated as 1) or saturating increment
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = ONE;
      len_d = (load_len == '0) ? ONE : load_len;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
    term_next = (cnt_d == len_d);
  end

  // Counter and latched length registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      len_q <= ONE;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpb_phase_sched.sv
// rtl/cpb_phase_sched.sv - per-phase completion scheduler for the CPB sequencing FSM
module cpb_phase_sched #(
  parameter int FSM_BITS = cpb_pkg::FSM_BITS,
  parameter int CNT_W    = 16,
  parameter int DEF_LEN  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FSM_BITS-1:0] state_in,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [CNT_W-1:0]    cfg_wdata,
  output logic                ld_req,
  output logic                ld_id,
  input  logic                ld_ack,
  input  logic                ld_done,
  output logic [6:0]          flag_end,
  output logic [CNT_W-1:0]    phase_cnt,
  output logic                sched_busy
);
  import cpb_pkg::*;

  localparam logic [FSM_BITS-1:0] CODE_IDLE = FSM_BITS'(ST_IDLE);
  localparam logic [FSM_BITS-1:0] CODE_MAX  = FSM_BITS'(ST_CPB_4);

  sched_state_e          st_q, st_d;
  logic [2:0]            idx_q, idx_d;
  logic [FSM_BITS-1:0]   last_state_q, last_state_d;
  logic [N_PHASES-1:0]   flag_q, flag_d;
  logic [CNT_W-1:0]      len_q [N_PHASES];
  logic [CNT_W-1:0]      len_d [N_PHASES];

  logic                  code_valid;
  logic                  entry;
  logic [2:0]            new_idx;
  logic [CNT_W-1:0]      new_len;
  logic                  term_next;

  // Classify the incoming state code and fetch the programmed length for it
  always_comb begin
    code_valid = (state_in != CODE_IDLE) && (state_in <= CODE_MAX);
    entry      = code_valid && (state_in != last_state_q);
    new_idx    = state_in[2:0] - 3'd1;
    new_len    = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      if (new_idx == 3'(i)) new_len = len_q[i];
    end
  end

  // Length register file; a write only matters at the next phase entry
  always_comb begin
    len_d = len_q;
    for (int i = 0; i < N_PHASES; i++) begin
      if (cfg_we && (cfg_addr == 3'(i))) len_d[i] = cfg_wdata;
    end
  end

  cpb_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (!code_valid),
    .load      (entry),
    .load_len  (new_len),
    .inc       (st_q != S_IDLE),
    .cnt       (phase_cnt),
    .term_next (term_next)
  );

  // Tracking FSM: idle override, then (re)entry, then per-state progress
  always_comb begin
    st_d         = st_q;
    idx_d        = idx_q;
    flag_d       = '0;
    last_state_d = state_in;
    if (!code_valid) begin
      st_d = S_IDLE;
    end else if (entry) begin
      idx_d = new_idx;
      if (is_load_phase(new_idx)) begin
        st_d = S_REQ;
      end else begin
        st_d = S_RUN;
        if (term_next) flag_d = N_PHASES'(1) << new_idx;
      end
    end else begin
      case (st_q)
        S_RUN: begin
          if (flag_q != '0) st_d = S_DONE;
          else if (term_next) flag_d = N_PHASES'(1) << idx_q;
        end
        S_REQ: begin
          if (ld_ack) st_d = S_WAIT;
        end
        S_WAIT: begin
          if (ld_done) begin
            st_d   = S_DONE;
            flag_d = N_PHASES'(1) << idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State, phase index, previous state code, flag and length registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= S_IDLE;
      idx_q        <= '0;
      last_state_q <= '0;
      flag_q       <= '0;
      for (int i = 0; i < N_PHASES; i++) len_q[i] <= CNT_W'(DEF_LEN);
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      last_state_q <= last_state_d;
      flag_q       <= flag_d;
      len_q        <= len_d;
    end
  end

  assign flag_end   = flag_q;
  assign ld_req     = (st_q == S_REQ);
  assign ld_id      = (idx_q == 3'(PH_LOADNEW));
  assign sched_busy = (st_q != S_IDLE) && (st_q != S_DONE);

endmodule
